// File: rtl/pll_dyn_ctrl_if.sv
// Request/status handshake of the PLL sequencer, plus the raw PLL-side pins it drives and observes.
// The master side is the SoC requester together with the PLL (or its model); the slave side is the sequencer.
interface pll_dyn_ctrl_if;
    logic       ps_req;
    logic [1:0] ps_sel;
    logic       ps_dir;
    logic [3:0] ps_cnt;
    logic       ps_busy;
    logic       ps_done;
    logic       ps_err;
    logic       ready;
    logic       locked;
    logic       pll_rst;
    logic       pll_lock;
    logic       phasestep;
    logic [1:0] phasesel;
    logic       phasedir;
    logic [3:0] pll_clk;

    modport master (
        output ps_req, ps_sel, ps_dir, ps_cnt, pll_lock, pll_clk,
        input  ps_busy, ps_done, ps_err, ready, locked, pll_rst, phasestep, phasesel, phasedir
    );

    modport slave (
        input  ps_req, ps_sel, ps_dir, ps_cnt, pll_lock, pll_clk,
        output ps_busy, ps_done, ps_err, ready, locked, pll_rst, phasestep, phasesel, phasedir
    );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// ECP5 EHXPLLL wrapper: PLL reset pulse, lock qualification into `ready`, and a
// request/done sequencer for dynamic fine-phase steps, all clocked by the reference clock.
module pll_dyn_ctrl #(
    parameter int unsigned CLKI_DIV   = 2,
    parameter int unsigned CLKFB_DIV  = 1,
    parameter int unsigned CLKOP_DIV  = 12,
    parameter int unsigned CLKOS_DIV  = 12,
    parameter int unsigned CLKOS2_DIV = 12,
    parameter int unsigned CLKOS3_DIV = 12,
    parameter int unsigned NUM_OUT    = 1,
    parameter int unsigned RST_CYC    = 16,
    parameter int unsigned SETTLE_W   = 10,
    parameter int unsigned PS_SETUP   = 2,
    parameter int unsigned PS_PULSE   = 2,
    parameter int unsigned PS_HOLD    = 2
) (
    input  logic          clki,
    input  logic          resetn,
    output logic [3:0]    clko,
    pll_dyn_ctrl_if.slave bus
);
    localparam int unsigned TMR_W  = $clog2(RST_CYC + PS_SETUP + PS_PULSE + PS_HOLD + 2);
    localparam int unsigned SCNT_W = SETTLE_W + 1;
    localparam logic [SCNT_W-1:0] SETTLE_MAX = {1'b0, {SETTLE_W{1'b1}}};
    // An output is live only if it is within NUM_OUT and the whole divider chain is configured.
    localparam logic [3:0] OUT_EN = {NUM_OUT >= 4 && CLKOS3_DIV >= 1,
                                     NUM_OUT >= 3 && CLKOS2_DIV >= 1,
                                     NUM_OUT >= 2 && CLKOS_DIV  >= 1,
                                     NUM_OUT >= 1 && CLKOP_DIV  >= 1}
                                    & {4{CLKI_DIV >= 1 && CLKFB_DIV >= 1}};

    typedef enum logic [2:0] {
        S_RST_HOLD, S_WAIT_LOCK, S_SETTLE, S_READY, S_PS_SETUP, S_PS_PULSE, S_PS_HOLD
    } state_t;

    state_t              state, state_d;
    logic [TMR_W-1:0]    tmr, tmr_d;
    logic [SCNT_W-1:0]   scnt, scnt_d;
    logic [3:0]          rem, rem_d;
    logic [1:0]          sel_q, sel_d;
    logic                dir_q, dir_d;
    logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                rst_q, rst_d, step_q, step_d;
    logic                lock_m, lock_s;
    logic                pll_lock;
    logic [3:0]          pll_clk;

`ifdef SYNTHESIS
    EHXPLLL #(
        .CLKI_DIV(CLKI_DIV), .CLKFB_DIV(CLKFB_DIV), .FEEDBK_PATH("CLKOP"),
        .CLKOP_ENABLE("ENABLED"),
        .CLKOS_ENABLE(NUM_OUT >= 2 ? "ENABLED" : "DISABLED"),
        .CLKOS2_ENABLE(NUM_OUT >= 3 ? "ENABLED" : "DISABLED"),
        .CLKOS3_ENABLE(NUM_OUT >= 4 ? "ENABLED" : "DISABLED"),
        .CLKOP_DIV(CLKOP_DIV),   .CLKOP_CPHASE(CLKOP_DIV - 1),   .CLKOP_FPHASE(0),
        .CLKOS_DIV(CLKOS_DIV),   .CLKOS_CPHASE(CLKOS_DIV - 1),   .CLKOS_FPHASE(0),
        .CLKOS2_DIV(CLKOS2_DIV), .CLKOS2_CPHASE(CLKOS2_DIV - 1), .CLKOS2_FPHASE(0),
        .CLKOS3_DIV(CLKOS3_DIV), .CLKOS3_CPHASE(CLKOS3_DIV - 1), .CLKOS3_FPHASE(0)
    ) u_pll (
        .CLKI(clki), .CLKFB(pll_clk[0]),
        .PHASESEL1(sel_q[1]), .PHASESEL0(sel_q[0]), .PHASEDIR(dir_q),
        .PHASESTEP(step_q), .PHASELOADREG(1'b0),
        .STDBY(1'b0), .PLLWAKESYNC(1'b0), .RST(rst_q),
        .ENCLKOP(1'b0), .ENCLKOS(1'b0), .ENCLKOS2(1'b0), .ENCLKOS3(1'b0),
        .CLKOP(pll_clk[0]), .CLKOS(pll_clk[1]), .CLKOS2(pll_clk[2]), .CLKOS3(pll_clk[3]),
        .LOCK(pll_lock), .INTLOCK(), .REFCLK(), .CLKINTFB()
    );
`else
    // Outside synthesis the PLL is supplied by the environment through the interface.
    assign pll_lock = bus.pll_lock;
    assign pll_clk  = bus.pll_clk;
`endif

    assign clko          = pll_clk & OUT_EN;
    assign bus.locked    = lock_s;
    assign bus.ready     = ready_q;
    assign bus.ps_busy   = busy_q;
    assign bus.ps_done   = done_q;
    assign bus.ps_err    = err_q;
    assign bus.pll_rst   = rst_q;
    assign bus.phasestep = step_q;
    assign bus.phasesel  = sel_q;
    assign bus.phasedir  = dir_q;

    // LOCK is asynchronous to clki.
    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            state   <= S_RST_HOLD;
            tmr     <= '0;
            scnt    <= '0;
            rem     <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rst_q   <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            state   <= state_d;
            tmr     <= tmr_d;
            scnt    <= scnt_d;
            rem     <= rem_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rst_q   <= rst_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state;
        tmr_d   = tmr;
        scnt_d  = scnt;
        rem_d   = rem;
        sel_d   = sel_q;
        dir_d   = dir_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rst_d   = 1'b0;
        step_d  = 1'b0;
        unique case (state)
            S_RST_HOLD: begin
                rst_d   = 1'b1;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (tmr == TMR_W'(RST_CYC)) begin
                    state_d = S_WAIT_LOCK;
                    tmr_d   = '0;
                    rst_d   = 1'b0;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                ready_d = 1'b0;
                if (lock_s) begin
                    state_d = S_SETTLE;
                    scnt_d  = '0;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (scnt == SETTLE_MAX) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end else begin
                    scnt_d = scnt + SCNT_W'(1);
                end
            end
            S_READY: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = busy_q;
                end else if (busy_q) begin
                    // Completion of a zero-count request accepted last cycle.
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (bus.ps_req) begin
                    sel_d  = bus.ps_sel;
                    dir_d  = bus.ps_dir;
                    rem_d  = bus.ps_cnt;
                    busy_d = 1'b1;
                    if (bus.ps_cnt != 4'd0) begin
                        state_d = S_PS_SETUP;
                        tmr_d   = '0;
                    end
                end
            end
            S_PS_SETUP, S_PS_PULSE, S_PS_HOLD: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (state == S_PS_SETUP) begin
                    if (tmr == TMR_W'(PS_SETUP - 1)) begin
                        state_d = S_PS_PULSE;
                        tmr_d   = '0;
                        step_d  = 1'b1;
                    end else begin
                        tmr_d = tmr + TMR_W'(1);
                    end
                end else if (state == S_PS_PULSE) begin
                    if (tmr == TMR_W'(PS_PULSE - 1)) begin
                        state_d = S_PS_HOLD;
                        tmr_d   = '0;
                    end else begin
                        tmr_d  = tmr + TMR_W'(1);
                        step_d = 1'b1;
                    end
                end else if (tmr == TMR_W'(PS_HOLD - 1)) begin
                    tmr_d = '0;
                    rem_d = rem - 4'd1;
                    if (rem == 4'd1) begin
                        state_d = S_READY;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PS_PULSE;
                        step_d  = 1'b1;
                    end
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end
            default: state_d = S_RST_HOLD;
        endcase
    end
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl: stimulus queues expected output events with their cycle,
// a negedge monitor pops and compares each event as the DUT produces it.
module tb_pll_dyn_ctrl;
    logic       clki;
    logic       resetn;
    logic [3:0] clko;

    pll_dyn_ctrl_if bus ();

    pll_dyn_ctrl dut (
        .clki   (clki),
        .resetn (resetn),
        .clko   (clko),
        .bus    (bus)
    );

    typedef enum logic [2:0] {
        EV_RST_FALL, EV_READY_FALL, EV_READY_RISE, EV_BUSY_RISE,
        EV_STEP_RISE, EV_STEP_FALL, EV_DONE, EV_ERR
    } ev_t;

    typedef struct {
        ev_t         kind;
        int unsigned cyc;
        bit          chk;
        logic [1:0]  sel;
        logic        dir;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic        prev_rst = 1'b1, prev_ready = 1'b0, prev_busy = 1'b0, prev_step = 1'b0;

    initial clki = 1'b0;
    always #5 clki = ~clki;
    always @(posedge clki) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clki);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_ev(input ev_t k, input int unsigned c, input bit chk = 1'b0,
                          input logic [1:0] s = 2'd0, input logic d = 1'b0);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.chk  = chk;
        e.sel  = s;
        e.dir  = d;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_t k);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL event %s at cycle %0d: got an event, want none", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || (bus.ps_done && bus.ps_err) ||
                (e.chk && (bus.phasesel != e.sel || bus.phasedir != e.dir))) begin
                n_err++;
                $display("FAIL event: got %s @%0d sel=%0d dir=%0d done=%b err=%b, want %s @%0d sel=%0d dir=%0d",
                         k.name(), cyc, bus.phasesel, bus.phasedir, bus.ps_done, bus.ps_err,
                         e.kind.name(), e.cyc, e.sel, e.dir);
            end
        end
    endtask

    // Event monitor: fixed in-cycle order matches the order stimulus pushes same-cycle events.
    always @(negedge clki) begin
        if (mon_en) begin
            if (prev_rst && !bus.pll_rst)    observe(EV_RST_FALL);
            if (prev_ready && !bus.ready)    observe(EV_READY_FALL);
            if (!prev_ready && bus.ready)    observe(EV_READY_RISE);
            if (!prev_busy && bus.ps_busy)   observe(EV_BUSY_RISE);
            if (!prev_step && bus.phasestep) observe(EV_STEP_RISE);
            if (prev_step && !bus.phasestep) observe(EV_STEP_FALL);
            if (bus.ps_done)                 observe(EV_DONE);
            if (bus.ps_err)                  observe(EV_ERR);
        end
        prev_rst   = bus.pll_rst;
        prev_ready = bus.ready;
        prev_busy  = bus.ps_busy;
        prev_step  = bus.phasestep;
    end

    initial begin
        int unsigned t, e;
        exp_t        p;
        resetn       = 1'b0;
        bus.ps_req   = 1'b0;
        bus.ps_sel   = 2'd0;
        bus.ps_dir   = 1'b0;
        bus.ps_cnt   = 4'd0;
        bus.pll_lock = 1'b0;
        bus.pll_clk  = 4'hF;
        step(3);

        check("reset ready",     32'(bus.ready),     32'd0);
        check("reset locked",    32'(bus.locked),    32'd0);
        check("reset ps_busy",   32'(bus.ps_busy),   32'd0);
        check("reset ps_done",   32'(bus.ps_done),   32'd0);
        check("reset ps_err",    32'(bus.ps_err),    32'd0);
        check("reset pll_rst",   32'(bus.pll_rst),   32'd1);
        check("reset phasestep", 32'(bus.phasestep), 32'd0);
        check("reset phasesel",  32'(bus.phasesel),  32'd0);
        check("reset phasedir",  32'(bus.phasedir),  32'd0);
        check("clko masking",    32'(clko),          32'h1);

        // Power-up: PLL RST high for 16 cycles, ready 1027 cycles after LOCK.
        t = cyc;
        resetn = 1'b1;
        mon_en = 1'b1;
        exp_ev(EV_RST_FALL, t + 17);
        step(100);
        t = cyc;
        bus.pll_lock = 1'b1;
        exp_ev(EV_READY_RISE, t + 1027);
        step(1027);
        check("ready after settle", 32'(bus.ready),  32'd1);
        check("locked after sync",  32'(bus.locked), 32'd1);

        // Lock loss from READY, then a request outside READY that must be dropped.
        step(5);
        t = cyc;
        bus.pll_lock = 1'b0;
        exp_ev(EV_READY_FALL, t + 3);
        step(5);
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd1;
        bus.ps_cnt = 4'd3;
        step(3);
        bus.ps_req = 1'b0;
        check("req ignored outside READY", 32'(bus.ps_busy), 32'd0);

        // Lock glitch of 5 cycles at settle count 500 restarts the settle count.
        step(2);
        bus.pll_lock = 1'b1;
        step(503);
        bus.pll_lock = 1'b0;
        step(5);
        t = cyc;
        bus.pll_lock = 1'b1;
        exp_ev(EV_READY_RISE, t + 1027);
        step(1027);
        check("ready after glitch", 32'(bus.ready), 32'd1);

        // Three steps on CLKOS2, lead; a mid-sequence request with other fields is ignored.
        step(3);
        e = cyc + 1;
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd2;
        bus.ps_dir = 1'b1;
        bus.ps_cnt = 4'd3;
        exp_ev(EV_BUSY_RISE, e);
        for (int i = 0; i < 3; i++) begin
            exp_ev(EV_STEP_RISE, e + 2 + 4 * i, 1'b1, 2'd2, 1'b1);
            exp_ev(EV_STEP_FALL, e + 4 + 4 * i, 1'b1, 2'd2, 1'b1);
        end
        exp_ev(EV_DONE, e + 14, 1'b1, 2'd2, 1'b1);
        step(1);
        bus.ps_req = 1'b0;
        check("busy after request", 32'(bus.ps_busy), 32'd1);
        step(4);
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd0;
        bus.ps_dir = 1'b0;
        bus.ps_cnt = 4'd1;
        step(1);
        bus.ps_req = 1'b0;
        step(11);
        check("busy cleared after done", 32'(bus.ps_busy), 32'd0);

        // Zero count held high: two back-to-back busy/done pairs, no stepping.
        t = cyc;
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd1;
        bus.ps_cnt = 4'd0;
        exp_ev(EV_BUSY_RISE, t + 1);
        exp_ev(EV_DONE,      t + 2);
        exp_ev(EV_BUSY_RISE, t + 3);
        exp_ev(EV_DONE,      t + 4);
        step(3);
        bus.ps_req = 1'b0;
        step(3);

        // Abort: LOCK drops during the second step pulse.
        e = cyc + 1;
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd1;
        bus.ps_dir = 1'b0;
        bus.ps_cnt = 4'd5;
        exp_ev(EV_BUSY_RISE, e);
        exp_ev(EV_STEP_RISE, e + 2, 1'b1, 2'd1, 1'b0);
        exp_ev(EV_STEP_FALL, e + 4, 1'b1, 2'd1, 1'b0);
        exp_ev(EV_STEP_RISE, e + 6, 1'b1, 2'd1, 1'b0);
        exp_ev(EV_STEP_FALL, e + 8, 1'b1, 2'd1, 1'b0);
        exp_ev(EV_READY_FALL, e + 9);
        exp_ev(EV_ERR,        e + 9);
        step(1);
        bus.ps_req = 1'b0;
        step(6);
        bus.pll_lock = 1'b0;
        step(3);
        check("abort ps_err",  32'(bus.ps_err),  32'd1);
        check("abort ps_busy", 32'(bus.ps_busy), 32'd0);
        check("abort ready",   32'(bus.ready),   32'd0);
        check("abort pll_rst", 32'(bus.pll_rst), 32'd0);
        step(1);
        check("ps_err one cycle", 32'(bus.ps_err), 32'd0);

        // Relock, start a sequence, then reset in the middle of it.
        t = cyc;
        bus.pll_lock = 1'b1;
        exp_ev(EV_READY_RISE, t + 1027);
        step(1029);
        e = cyc + 1;
        bus.ps_req = 1'b1;
        bus.ps_sel = 2'd3;
        bus.ps_dir = 1'b1;
        bus.ps_cnt = 4'd4;
        exp_ev(EV_BUSY_RISE, e);
        exp_ev(EV_STEP_RISE, e + 2, 1'b1, 2'd3, 1'b1);
        exp_ev(EV_STEP_FALL, e + 4, 1'b1, 2'd3, 1'b1);
        exp_ev(EV_STEP_RISE, e + 6, 1'b1, 2'd3, 1'b1);
        step(1);
        bus.ps_req = 1'b0;
        step(7);
        mon_en = 1'b0;
        #2;
        resetn = 1'b0;
        bus.pll_lock = 1'b0;
        #1;
        check("async rst ready",     32'(bus.ready),     32'd0);
        check("async rst ps_busy",   32'(bus.ps_busy),   32'd0);
        check("async rst phasestep", 32'(bus.phasestep), 32'd0);
        check("async rst phasesel",  32'(bus.phasesel),  32'd0);
        check("async rst phasedir",  32'(bus.phasedir),  32'd0);
        check("async rst pll_rst",   32'(bus.pll_rst),   32'd1);
        check("async rst locked",    32'(bus.locked),    32'd0);
        step(2);
        t = cyc;
        resetn = 1'b1;
        mon_en = 1'b1;
        exp_ev(EV_RST_FALL, t + 17);
        step(20);
        check("pll_rst released again", 32'(bus.pll_rst), 32'd0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            p = sb[0];
            $display("FAIL pending events: got %0d left (first %s due @%0d), want 0",
                     sb.size(), p.kind.name(), p.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pll_dyn_ctrl.md
# pll_dyn_ctrl

Parametrised ECP5 PLL block: instantiates one EHXPLLL with up to four configurable outputs and wraps it in a sequencer clocked by the PLL reference clock. The sequencer pulses the PLL reset, qualifies and debounces LOCK into a single `ready` flag, and runs a request/done handshake that issues dynamic fine-phase steps on a selected output. It sits at the top of a SoC, between the board oscillator and the clock and reset fabric.

## Interface

Parameters:
- `CLKI_DIV`, 2: reference input divider.
- `CLKFB_DIV`, 1: feedback divider.
- `CLKOP_DIV`, 12: CLKOP output divider.
- `CLKOS_DIV`, 12: CLKOS output divider.
- `CLKOS2_DIV`, 12: CLKOS2 output divider.
- `CLKOS3_DIV`, 12: CLKOS3 output divider.
- `NUM_OUT`, 1: number of enabled outputs, 1..4. Outputs CLKOP..CLKOS3 are enabled in that order; disabled outputs are tied 0.
- `RST_CYC`, 16: number of cycles the PLL RST is held high after reset release.
- `SETTLE_W`, 10: LOCK must be stable for 2^SETTLE_W cycles before `ready` rises.
- `PS_SETUP`, 2: cycles PHASESEL/PHASEDIR are held before each step pulse.
- `PS_PULSE`, 2: cycles PHASESTEP is held high.
- `PS_HOLD`, 2: cycles PHASESTEP is held low after each pulse.

Ports:
- `clki`, in, 1: reference clock. It drives the PLL input and all sequencer logic.
- `resetn`, in, 1: asynchronous, active-low reset.
- `clko`, out, 4: PLL outputs {CLKOS3, CLKOS2, CLKOS, CLKOP}. Feedback is CLKOP.
- `ready`, out, 1: PLL is locked and settled.
- `locked`, out, 1: raw PLL LOCK after a 2-flop synchroniser.
- `ps_req`, in, 1: phase-step request. Sampled only in READY.
- `ps_sel`, in, 2: output select (0 = CLKOP … 3 = CLKOS3).
- `ps_dir`, in, 1: direction, 0 = lag, 1 = lead (PHASEDIR).
- `ps_cnt`, in, 4: number of steps, 0..15.
- `ps_busy`, out, 1: a step sequence is in progress.
- `ps_done`, out, 1: one-cycle pulse when a sequence completes.
- `ps_err`, out, 1: one-cycle pulse when a sequence is aborted by loss of lock.

## Operation

- **Lock synchroniser.** PLL LOCK is asynchronous to `clki` and passes through a 2-flop synchroniser to give `lock_s`.
- **RST_HOLD.** PLL RST = 1. A counter runs for RST_CYC cycles, then the FSM moves to WAIT_LOCK.
- **WAIT_LOCK.** PLL RST = 0. On `lock_s` = 1, clear the settle counter and move to SETTLE.
- **SETTLE.** The settle counter (SETTLE_W+1 bits) increments every cycle.
  - `lock_s` = 0: return to WAIT_LOCK.
  - Counter reaches 2^SETTLE_W − 1: move to READY.
- **READY.** `ready` = 1.
  - `lock_s` = 0: `ready` = 0 and the FSM goes to WAIT_LOCK.
  - `ps_req` = 1 (lock held): latch `ps_sel`, `ps_dir`, `ps_cnt` and raise `ps_busy`.
    - Latched count 0: pulse `ps_done` the next cycle, issue no pulses, stay in READY.
    - Otherwise move to PS_SETUP.
- **PS_SETUP.** Drive PHASESEL = latched sel and PHASEDIR = latched dir for PS_SETUP cycles, then move to PS_PULSE.
- **PS_PULSE.** PHASESTEP = 1 for PS_PULSE cycles, then move to PS_HOLD.
- **PS_HOLD.** PHASESTEP = 0 for PS_HOLD cycles, then decrement the remaining count.
  - Remaining count nonzero: return to PS_PULSE. PHASESEL/PHASEDIR stay stable, so there is no new setup.
  - Remaining count zero: pulse `ps_done`, clear `ps_busy`, return to READY.
- **PS_\* states:** `ready` stays 1.
- **Loss of lock in any PS_\* state:**
  - Force PHASESTEP = 0.
  - Pulse `ps_err`.
  - Clear `ps_busy`.
  - Clear `ready`.
  - Go to WAIT_LOCK.
- **Request gating.**
  - `ps_req` outside READY is ignored. It is not queued.
  - `ps_req` held high after `ps_done` starts a new sequence, beginning the cycle after the `ps_done` pulse.
- **Static PLL settings.** STDBY, PLLWAKESYNC and ENCLK* are tied 0. Output CPHASE defaults to DIV−1 and FPHASE to 0.

## Timing

- **Reset values** (async, while `resetn` = 0):
  - FSM = RST_HOLD, PLL RST = 1.
  - `ready`, `locked`, `ps_busy`, `ps_done`, `ps_err` = 0.
  - PHASESTEP, PHASESEL, PHASEDIR = 0.
  - All counters = 0.
- **Reset mid-operation:** any state returns to RST_HOLD immediately and all outputs take their reset values.
- **PLL reset pulse:** PLL RST falls exactly RST_CYC cycles after the first `clki` edge with `resetn` = 1.
- **Lock to ready:** `ready` rises 2 (sync) + 1 + 2^SETTLE_W cycles after LOCK rises, provided LOCK stays high throughout.
- **Lock loss:** `ready` falls 3 cycles after LOCK falls (2 sync + 1).
- **Request to busy:** `ps_busy` rises the cycle after `ps_req` is sampled.
- **Sequence length** for N ≥ 1 steps: PS_SETUP + N·(PS_PULSE+PS_HOLD) cycles. `ps_done` is asserted in the cycle after the last hold cycle.
- **Pulse widths:** `ps_done` and `ps_err` are exactly one cycle wide and are never asserted together.

## Test plan

- **Power-up:** defaults; release `resetn`, LOCK model rises 100 cycles later.
  - PLL RST is high for exactly 16 cycles.
  - `ready` rises at LOCK + 1027 cycles.
- **Lock glitch:** drop LOCK for 5 cycles during SETTLE at count 500.
  - Settle counter restarts.
  - `ready` rises 1027 cycles after LOCK returns.
- **Phase step:** request sel = 2, dir = 1, cnt = 3 in READY.
  - PHASESEL = 2 and PHASEDIR = 1, stable throughout.
  - Three 2-cycle PHASESTEP pulses spaced 4 cycles apart.
  - `ps_done` arrives 14 cycles after `ps_busy` rises.
- **Zero count:** request with cnt = 0.
  - No PHASESTEP activity.
  - `ps_done` pulses one cycle after `ps_busy`.
- **Abort:** drop LOCK during the second PHASESTEP pulse.
  - PHASESTEP returns to 0 within 3 cycles.
  - `ps_err` pulses once.
  - `ready` = 0, FSM is in WAIT_LOCK.
- **Reset mid-sequence:** assert `resetn` = 0 mid-sequence.
  - All outputs take reset values asynchronously.
  - After release, the PLL RST sequence repeats.
